program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader.sv | 95 +++++++++
 tb/tb_program_loader.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Streams a length byte plus MSB-first instruction bytes into instruction memory, then releases the CPU from reset.
// One imem write cycle per assembled instruction; RUN (cpu_reset low) begins the cycle after the final write.
// byte_ready is high only in LEN/LOAD; bytes move on valid&ready, and any gap between bytes is tolerated.
module program_loader #(
   parameter int ADDR_W  = 8,
   parameter int INSTR_W = 24
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               start,
   input  logic               halt,
   input  logic [7:0]         byte_in,
   input  logic               byte_valid,
   output logic               byte_ready,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_reset,
   output logic               busy,
   output logic               running
);

   localparam int NB    = INSTR_W / 8;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NB - 1);

   typedef enum logic [2:0] {IDLE, LEN, LOAD, WRITE, RUN} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [ADDR_W-1:0]  waddr;
   logic [INSTR_W-1:0] instr;
   logic [7:0]         len;
   logic [CNT_W-1:0]   bcnt;
   logic               xfer;
   logic               last_instr;

   // A byte moves only when both sides agree; the length byte caps the final write address.
   assign xfer       = byte_valid & byte_ready;
   assign last_instr = (waddr == ADDR_W'(len));
   assign imem_addr  = waddr;
   assign imem_wdata = instr;

   // Next-state decode; start/halt are only looked at in the state that owns them.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = LEN;
         LEN:     if (xfer) state_nxt = LOAD;
         LOAD:    if (xfer && bcnt == CNT_LAST) state_nxt = WRITE;
         WRITE:   state_nxt = last_instr ? RUN : LOAD;
         RUN:     if (halt) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered outputs; reset overrides every request in the same cycle.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state      <= IDLE;
         waddr      <= '0;
         instr      <= '0;
         len        <= '0;
         bcnt       <= '0;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         running    <= 1'b0;
      end else begin
         state      <= state_nxt;
         byte_ready <= (state_nxt == LEN) || (state_nxt == LOAD);
         imem_we    <= (state_nxt == WRITE);
         busy       <= (state_nxt == LEN) || (state_nxt == LOAD) || (state_nxt == WRITE);
         running    <= (state_nxt == RUN);
         cpu_reset  <= (state_nxt != RUN);

         if (state == IDLE && start) begin
            waddr <= '0;
            bcnt  <= '0;
         end
         if (state == LEN && xfer) begin
            len  <= byte_in;
            bcnt <= '0;
         end
         if (state == LOAD && xfer) begin
            instr <= (instr << 8) | INSTR_W'(byte_in);
            bcnt  <= (bcnt == CNT_LAST) ? '0 : bcnt + CNT_W'(1);
         end
         if (state == WRITE)
            waddr <= waddr + ADDR_W'(1);
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: back-to-back and gapped loads, full 256-entry load, reset mid-load, halt.
// Inputs change 1 time unit after the rising edge; outputs are checked there and writes are logged on the falling edge.
// Every handshake wait is bounded so the run always reaches its summary line.
module tb_program_loader;

   logic        CLK = 1'b0;
   logic        reset, start, halt, byte_valid;
   logic [7:0]  byte_in;
   logic        byte_ready, imem_we, cpu_reset, busy, running;
   logic [7:0]  imem_addr;
   logic [23:0] imem_wdata;

   int n_cmp = 0;
   int n_err = 0;
   int rdy_viol = 0;
   logic [7:0]  wa[$];
   logic [23:0] wd[$];

   program_loader #(.ADDR_W(8), .INSTR_W(24)) dut (
      .CLK(CLK), .reset(reset), .start(start), .halt(halt),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .running(running)
   );

   always #5 CLK = ~CLK;

   // Log every memory write; byte_ready must never be high in a write cycle.
   always @(negedge CLK) begin
      if (imem_we) begin
         wa.push_back(imem_addr);
         wd.push_back(imem_wdata);
         if (byte_ready) rdy_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Offer one byte and wait (bounded) for it to be taken; gap mode idles one cycle afterwards with junk on byte_in.
   task automatic send(input logic [7:0] b, input bit gap);
      int k;
      byte_in    = b;
      byte_valid = 1'b1;
      k = 0;
      while (!byte_ready && k < 20) begin
         tick();
         k++;
      end
      if (!byte_ready) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
      tick();
      if (gap) begin
         byte_valid = 1'b0;
         byte_in    = 8'hEE;
         tick();
      end
   endtask

   task automatic load_instr(input logic [23:0] w, input bit gap);
      send(w[23:16], gap);
      send(w[15:8], gap);
      send(w[7:0], gap);
   endtask

   function automatic logic [23:0] pat(input int i);
      logic [7:0] v;
      v = i[7:0];
      return {v, ~v, v ^ 8'h5A};
   endfunction

   initial begin
      int bad;
      reset = 1'b1; start = 1'b0; halt = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
      tick(); tick();
      chk("rst_byte_ready", 32'(byte_ready), 32'd0);
      chk("rst_imem_we",    32'(imem_we),    32'd0);
      chk("rst_cpu_reset",  32'(cpu_reset),  32'd1);
      chk("rst_busy",       32'(busy),       32'd0);
      chk("rst_running",    32'(running),    32'd0);
      reset = 1'b0;
      tick();
      chk("idle_cpu_reset", 32'(cpu_reset), 32'd1);

      // Back-to-back two-instruction load
      start = 1'b1; tick(); start = 1'b0;
      chk("a_len_busy",  32'(busy),       32'd1);
      chk("a_len_ready", 32'(byte_ready), 32'd1);
      send(8'h01, 1'b0);
      load_instr(24'h1A2305, 1'b0);
      chk("a_w0_we",    32'(imem_we),    32'd1);
      chk("a_w0_addr",  32'(imem_addr),  32'd0);
      chk("a_w0_data",  32'(imem_wdata), 32'h1A2305);
      chk("a_w0_ready", 32'(byte_ready), 32'd0);
      load_instr(24'h2B40FF, 1'b0);
      byte_valid = 1'b0;
      chk("a_w1_we",    32'(imem_we),    32'd1);
      chk("a_w1_addr",  32'(imem_addr),  32'd1);
      chk("a_w1_data",  32'(imem_wdata), 32'h2B40FF);
      chk("a_w1_cpurst", 32'(cpu_reset), 32'd1);
      tick();
      chk("a_run_cpurst", 32'(cpu_reset), 32'd0);
      chk("a_run_running", 32'(running), 32'd1);
      chk("a_run_busy",  32'(busy),      32'd0);
      chk("a_run_we",    32'(imem_we),   32'd0);
      chk("a_nwrites",   32'(wa.size()), 32'd2);
      chk("a_log0_addr", 32'(wa[0]), 32'd0);
      chk("a_log0_data", 32'(wd[0]), 32'h1A2305);
      chk("a_log1_addr", 32'(wa[1]), 32'd1);
      chk("a_log1_data", 32'(wd[1]), 32'h2B40FF);

      // RUN holds; start ignored there; one-cycle halt returns to IDLE
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0;
      chk("run_start_ignored", 32'(running), 32'd1);
      halt = 1'b1; tick(); halt = 1'b0;
      chk("halt_running", 32'(running),   32'd0);
      chk("halt_cpurst",  32'(cpu_reset), 32'd1);
      chk("halt_busy",    32'(busy),      32'd0);

      // Same load with byte_valid toggling; start+halt together in IDLE; start pulsed during LOAD
      wa.delete(); wd.delete();
      start = 1'b1; halt = 1'b1; tick(); start = 1'b0; halt = 1'b0;
      chk("b_start_wins", 32'(busy), 32'd1);
      send(8'h01, 1'b1);
      send(8'h1A, 1'b1);
      start = 1'b1;
      send(8'h23, 1'b1);
      send(8'h05, 1'b1);
      start = 1'b0;
      load_instr(24'h2B40FF, 1'b1);
      chk("b_running",   32'(running),   32'd1);
      chk("b_cpurst",    32'(cpu_reset), 32'd0);
      chk("b_nwrites",   32'(wa.size()), 32'd2);
      chk("b_log0_addr", 32'(wa[0]), 32'd0);
      chk("b_log0_data", 32'(wd[0]), 32'h1A2305);
      chk("b_log1_addr", 32'(wa[1]), 32'd1);
      chk("b_log1_data", 32'(wd[1]), 32'h2B40FF);
      chk("b_ready_in_write", 32'(rdy_viol), 32'd0);
      halt = 1'b1; tick(); halt = 1'b0;

      // Full 256-instruction load: no address wrap, RUN after the write to 255
      wa.delete(); wd.delete();
      start = 1'b1; tick(); start = 1'b0;
      send(8'hFF, 1'b0);
      for (int i = 0; i < 256; i++) load_instr(pat(i), 1'b0);
      byte_valid = 1'b0;
      chk("c_last_we",   32'(imem_we),   32'd1);
      chk("c_last_addr", 32'(imem_addr), 32'hFF);
      tick();
      chk("c_running",   32'(running),   32'd1);
      chk("c_nwrites",   32'(wa.size()), 32'd256);
      bad = 0;
      for (int i = 0; i < 256 && i < wa.size(); i++)
         if (wa[i] !== i[7:0] || wd[i] !== pat(i)) bad++;
      chk("c_contents", 32'(bad), 32'd0);
      halt = 1'b1; tick(); halt = 1'b0;

      // Reset mid-instruction-1 (with start and a valid byte in the same cycle), then reload
      wa.delete(); wd.delete();
      start = 1'b1; tick(); start = 1'b0;
      send(8'h01, 1'b0);
      load_instr(24'h0A0B0C, 1'b0);
      send(8'h0D, 1'b0);
      send(8'h0E, 1'b0);
      byte_in = 8'h0F; byte_valid = 1'b1; reset = 1'b1; start = 1'b1;
      tick();
      reset = 1'b0; start = 1'b0; byte_valid = 1'b0;
      chk("d_rst_ready",  32'(byte_ready), 32'd0);
      chk("d_rst_busy",   32'(busy),       32'd0);
      chk("d_rst_cpurst", 32'(cpu_reset),  32'd1);
      chk("d_rst_we",     32'(imem_we),    32'd0);
      tick(); tick(); tick();
      chk("d_nwrites",   32'(wa.size()), 32'd1);
      chk("d_log0_addr", 32'(wa[0]), 32'd0);
      chk("d_log0_data", 32'(wd[0]), 32'h0A0B0C);
      chk("d_still_idle", 32'(busy), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      send(8'h00, 1'b0);
      load_instr(24'hABCDEF, 1'b0);
      byte_valid = 1'b0;
      chk("d_reload_we",   32'(imem_we),    32'd1);
      chk("d_reload_addr", 32'(imem_addr),  32'd0);
      chk("d_reload_data", 32'(imem_wdata), 32'hABCDEF);
      tick();
      chk("d_reload_run",  32'(running),    32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
